// File: rtl/clk_period_meter_if.sv
// Result bus of the period meter: measured period/high phase plus status.
// master drives period, high_time, period_valid, timeout, locked; slave reads them.
interface clk_period_meter_if #(
  parameter int CNT_W = 33
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;
  logic             locked;

  modport master (
    output period,
    output high_time,
    output period_valid,
    output timeout,
    output locked
  );

  modport slave (
    input period,
    input high_time,
    input period_valid,
    input timeout,
    input locked
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high phase of sig_in in clk_in cycles, flags timeout and lock.
// Ports: clk_in, rst_n, sig_in, clr; results on bus (clk_period_meter_if.master).
module clk_period_meter #(
  parameter int CNT_W       = 33,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                sig_in,
  input  logic                clr,
  clk_period_meter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TMO
  } state_t;

  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
  localparam logic [3:0]       LK_V  = 4'(LOCK_CNT);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;
  logic                   s;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_r;
  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] diff;
  logic             have_prev;
  logic [3:0]       match_cnt;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~dly;
  assign fall = ~s & dly;
  // absolute difference without signed arithmetic
  assign diff = (cnt >= prev) ? (cnt - prev) : (prev - cnt);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      dly  <= s;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (rise) state_nx = MEASURE;
        MEASURE: if (!rise && cnt == TO_V) state_nx = TMO;
        TMO:     if (rise) state_nx = MEASURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      hi_r             <= '0;
      prev             <= '0;
      have_prev        <= 1'b0;
      match_cnt        <= '0;
      bus.period       <= '0;
      bus.high_time    <= '0;
      bus.period_valid <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.locked       <= 1'b0;
    end else begin
      bus.period_valid <= 1'b0;
      if (clr) begin
        cnt           <= '0;
        hi_r          <= '0;
        prev          <= '0;
        have_prev     <= 1'b0;
        match_cnt     <= '0;
        bus.period    <= '0;
        bus.high_time <= '0;
        bus.timeout   <= 1'b0;
        bus.locked    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= rise ? CNT_W'(1) : '0;
          end
          MEASURE: begin
            if (rise) begin
              bus.period       <= cnt;
              bus.high_time    <= hi_r;
              bus.period_valid <= 1'b1;
              cnt              <= CNT_W'(1);
              prev             <= cnt;
              have_prev        <= 1'b1;
              if (!have_prev) begin
                match_cnt  <= '0;
                bus.locked <= 1'b0;
              end else if (diff <= TOL_V) begin
                if (match_cnt < LK_V) match_cnt <= match_cnt + 4'd1;
                bus.locked <= (match_cnt >= LK_V - 4'd1);
              end else begin
                match_cnt  <= '0;
                bus.locked <= 1'b0;
              end
            end else if (cnt == TO_V) begin
              // cnt is held here so it never passes TIMEOUT_CYC
              bus.timeout <= 1'b1;
              bus.locked  <= 1'b0;
              match_cnt   <= '0;
              have_prev   <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (fall) hi_r <= cnt;
            end
          end
          TMO: begin
            if (rise) begin
              cnt         <= CNT_W'(1);
              bus.timeout <= 1'b0;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: periods, duty, lock, timeout, clr, reset.
// Drives sig_in cycle by cycle and checks the result bus with immediate asserts.
module tb_clk_period_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int vcyc = -1;
  int to_cyc = -1;
  logic [63:0] lp = '0;
  logic [63:0] lh = '0;
  logic lk [64];

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(33)) bus ();

  clk_period_meter #(
    .CNT_W(33),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(100),
    .LOCK_CNT(4),
    .TOL(2)
  ) dut (
    .clk_in(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .clr(clr),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.period_valid) begin
      vcnt++;
      lp = 64'(bus.period);
      lh = 64'(bus.high_time);
      lk[vcnt % 64] = bus.locked;
      vcyc = cyc;
    end
    if (bus.timeout && to_cyc < 0) to_cyc = cyc;
  endtask

  task automatic wave(input int h, input int p, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        sig_in = (i < h);
        tick();
      end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 64'(bus.period), 64'd0);
    chk({tag, "_high"}, 64'(bus.high_time), 64'd0);
    chk({tag, "_valid"}, 64'(bus.period_valid), 64'd0);
    chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    chk({tag, "_locked"}, 64'(bus.locked), 64'd0);
  endtask

  initial begin
    // 1. reset with sig_in toggling
    for (int i = 0; i < 10; i++) begin
      sig_in = i[0];
      tick();
    end
    chk_zero("rst");
    chk("rst_novalid", 64'(vcnt), 64'd0);
    sig_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // 2. square 8/4, lock on 5th valid
    vcnt = 0;
    wave(4, 8, 1);
    chk("first_rise_novalid", 64'(vcnt), 64'd0);
    wave(4, 8, 5);
    chk("sq_vcnt", 64'(vcnt), 64'd5);
    chk("sq_period", lp, 64'd8);
    chk("sq_high", lh, 64'd4);
    chk("sq_lock4", 64'(lk[4]), 64'd0);
    chk("sq_lock5", 64'(lk[5]), 64'd1);

    // 3. duty 3/10, then jump to 20/10
    vcnt = 0;
    wave(3, 10, 6);
    chk("d10_vcnt", 64'(vcnt), 64'd6);
    chk("d10_period", lp, 64'd10);
    chk("d10_high", lh, 64'd3);
    chk("d10_lock", 64'(lk[6]), 64'd1);
    vcnt = 0;
    wave(10, 20, 6);
    chk("j20_lock1", 64'(lk[1]), 64'd1);
    chk("j20_drop", 64'(lk[2]), 64'd0);
    chk("j20_lock5", 64'(lk[5]), 64'd0);
    chk("j20_relock", 64'(lk[6]), 64'd1);
    chk("j20_period", lp, 64'd20);
    chk("j20_high", lh, 64'd10);

    // 4. lock at 9, jitter 8/10 holds, 13 after 10 drops
    vcnt = 0;
    wave(4, 9, 6);
    chk("p9_lock", 64'(lk[6]), 64'd1);
    vcnt = 0;
    wave(4, 8, 1);
    wave(4, 10, 1);
    wave(4, 8, 1);
    wave(4, 10, 1);
    wave(4, 13, 1);
    wave(4, 10, 1);
    for (int i = 1; i <= 5; i++) chk("jit_hold", 64'(lk[i]), 64'd1);
    chk("jit_drop", 64'(lk[6]), 64'd0);
    chk("jit_period13", lp, 64'd13);

    // 5. timeout 100 cycles after last rise
    to_cyc = -1;
    sig_in = 1'b0;
    for (int i = 0; i < 150 && to_cyc < 0; i++) tick();
    chk("to_delay", 64'(to_cyc - vcyc), 64'd100);
    chk("to_flag", 64'(bus.timeout), 64'd1);
    chk("to_unlock", 64'(bus.locked), 64'd0);
    vcnt = 0;
    wave(4, 8, 1);
    chk("to_clear", 64'(bus.timeout), 64'd0);
    chk("to_restart_novalid", 64'(vcnt), 64'd0);
    wave(4, 8, 1);
    chk("to_restart_vcnt", 64'(vcnt), 64'd1);
    chk("to_restart_period", lp, 64'd8);
    chk("to_restart_lock", 64'(bus.locked), 64'd0);

    // 6a. clr coincident with rise
    vcnt = 0;
    sig_in = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_novalid", 64'(vcnt), 64'd0);
    chk("clr_period", 64'(bus.period), 64'd0);
    chk("clr_high", 64'(bus.high_time), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    sig_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    wave(4, 8, 1);
    chk("clr_first_rise", 64'(vcnt), 64'd0);
    wave(4, 8, 1);
    chk("clr_vcnt", 64'(vcnt), 64'd1);
    chk("clr_period8", lp, 64'd8);

    // 6b. async reset mid-period
    sig_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk_zero("mrst");
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vcnt = 0;
    wave(4, 8, 1);
    chk("mrst_first_rise", 64'(vcnt), 64'd0);
    wave(4, 8, 1);
    chk("mrst_vcnt", 64'(vcnt), 64'd1);
    chk("mrst_period", lp, 64'd8);
    chk("mrst_high", lh, 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
